// File: rtl/tlb_inv_seq.sv
// INVTLB walk sequencer and TLB write-port arbiter. Steps through every TLB entry over the read
// port, clears entries that match the latched INVTLB operands, and yields to external writes.
module tlb_inv_seq #(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDXW   = $clog2(TLBNUM),
  parameter int unsigned ENTW   = 89
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            inv_valid,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  output logic            inv_ready,
  output logic            busy,
  output logic            inv_done,
  output logic            inv_ine,
  input  logic            ext_we,
  input  logic [IDXW-1:0] ext_w_index,
  input  logic [ENTW-1:0] ext_w_entry,
  output logic [IDXW-1:0] r_index,
  input  logic            r_e,
  input  logic [18:0]     r_vppn,
  input  logic [5:0]      r_ps,
  input  logic [9:0]      r_asid,
  input  logic            r_g,
  output logic            we,
  output logic [IDXW-1:0] w_index,
  output logic [ENTW-1:0] w_entry
);

  localparam logic [IDXW-1:0] LastIdx = IDXW'(TLBNUM - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] r_index_q, r_index_d;
  logic [2:0]      op_q, op_d;
  logic [9:0]      asid_q, asid_d;
  logic [18:0]     vppn_q, vppn_d;
  logic            ine_q, ine_d;

  logic asid_eq, va_eq, match, seq_we;

  always_comb begin
    asid_eq = (r_asid == asid_q);
    // 4 KiB pages compare the full VPPN; large pages ignore the low 9 bits.
    va_eq   = (r_ps == 6'd12) ? (r_vppn == vppn_q) : (r_vppn[18:9] == vppn_q[18:9]);
    case (op_q)
      3'd0, 3'd1: match = 1'b1;
      3'd2:       match = r_g;
      3'd3:       match = !r_g;
      3'd4:       match = !r_g && asid_eq;
      3'd5:       match = !r_g && asid_eq && va_eq;
      3'd6:       match = (r_g || asid_eq) && va_eq;
      default:    match = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    r_index_d = r_index_q;
    op_d      = op_q;
    asid_d    = asid_q;
    vppn_d    = vppn_q;
    ine_d     = 1'b0;
    seq_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (inv_valid) begin
          if (inv_op <= 5'd6) begin
            op_d      = inv_op[2:0];
            asid_d    = inv_asid;
            vppn_d    = inv_vppn;
            r_index_d = '0;
            state_d   = StRun;
          end else begin
            ine_d = 1'b1;
          end
        end
      end
      StRun: begin
        // An external write owns the port; hold the index and re-check the entry next cycle.
        if (!ext_we) begin
          seq_we = r_e && match;
          if (r_index_q == LastIdx) begin
            r_index_d = '0;
            state_d   = StDone;
          end else begin
            r_index_d = r_index_q + 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    we      = rstn && (ext_we || seq_we);
    w_index = ext_w_index;
    w_entry = ext_w_entry;
    if (!ext_we && seq_we) begin
      w_index = r_index_q;
      w_entry = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      r_index_q <= '0;
      op_q      <= '0;
      asid_q    <= '0;
      vppn_q    <= '0;
      ine_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_index_q <= r_index_d;
      op_q      <= op_d;
      asid_q    <= asid_d;
      vppn_q    <= vppn_d;
      ine_q     <= ine_d;
    end
  end

  assign inv_ready = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign inv_done  = (state_q == StDone);
  assign inv_ine   = ine_q;
  assign r_index   = r_index_q;

endmodule

// File: tb/tb_tlb_inv_seq.sv
// Scoreboard bench for tlb_inv_seq: a bench-owned TLB array, a reference walk model and a
// write-port monitor that pops expected writes in order.
module tb_tlb_inv_seq;
  localparam int N = 16;

  logic        clk, rstn, inv_valid, inv_ready, busy, inv_done, inv_ine;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vppn;
  logic        ext_we, r_e, r_g, we;
  logic [3:0]  ext_w_index, r_index, w_index;
  logic [88:0] ext_w_entry, w_entry;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;

  tlb_inv_seq #(.TLBNUM(N), .IDXW(4), .ENTW(89)) dut (
    .clk(clk), .rstn(rstn), .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid),
    .inv_vppn(inv_vppn), .inv_ready(inv_ready), .busy(busy), .inv_done(inv_done),
    .inv_ine(inv_ine), .ext_we(ext_we), .ext_w_index(ext_w_index), .ext_w_entry(ext_w_entry),
    .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
    .we(we), .w_index(w_index), .w_entry(w_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TLB storage seen by the DUT
  logic [88:0] tlb [N];
  always @(posedge clk) if (we) tlb[w_index] <= w_entry;
  assign r_e    = tlb[r_index][88];
  assign r_vppn = tlb[r_index][87:69];
  assign r_ps   = tlb[r_index][68:63];
  assign r_asid = tlb[r_index][62:53];
  assign r_g    = tlb[r_index][52];

  typedef struct packed {logic [3:0] idx; logic [88:0] ent;} wr_t;
  wr_t         exp_q[$];
  logic [88:0] ref_mem [N];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [88:0] act, input logic [88:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    wr_t x;
    forever begin
      @(negedge clk);
      if (we) begin
        checks++;
        if (!rstn) begin
          errors++;
          $display("FAIL write_in_reset: got we=1 idx=%0d expected no write", w_index);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got idx=%0d entry=%0h expected none", w_index, w_entry);
        end else begin
          x = exp_q.pop_front();
          if (x.idx !== w_index || x.ent !== w_entry) begin
            errors++;
            $display("FAIL write_port: got idx=%0d entry=%0h expected idx=%0d entry=%0h",
                     w_index, w_entry, x.idx, x.ent);
          end
        end
      end
    end
  endtask

  function automatic logic [88:0] mk(input bit e, input logic [18:0] vppn, input logic [5:0] ps,
                                     input logic [9:0] asid, input bit g);
    logic [63:0] rnd;
    rnd = {$urandom(), $urandom()};
    return {e, vppn, ps, asid, g, rnd[51:0]};
  endfunction

  // INVTLB rule, written from the instruction definition
  function automatic bit ref_hit(input logic [88:0] ent, input int op, input logic [9:0] asid,
                                 input logic [18:0] va);
    logic [18:0] evppn;
    bit same_asid, same_va, global;
    evppn     = ent[87:69];
    global    = ent[52];
    same_asid = (ent[62:53] == asid);
    if (ent[68:63] == 6'd12) same_va = (evppn == va);
    else                     same_va = (evppn[18:9] == va[18:9]);
    if (!ent[88]) return 0;
    if (op == 0 || op == 1) return 1;
    if (op == 2) return global;
    if (op == 3) return !global;
    if (op == 4) return !global && same_asid;
    if (op == 5) return !global && same_asid && same_va;
    if (op == 6) return (global || same_asid) && same_va;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_write(input int idx, input logic [88:0] ent);
    exp_q.push_back('{idx: 4'(idx), ent: ent});
    ref_mem[idx] = ent;
    ext_we = 1'b1; ext_w_index = 4'(idx); ext_w_entry = ent;
    tick();
    ext_we = 1'b0;
  endtask

  task automatic run_inv(input int op, input logic [9:0] asid, input logic [18:0] va,
                         input bit sim_en, input int sim_idx, input logic [88:0] sim_ent,
                         input int mid_idx, input int mid_cnt, input logic [88:0] mid_ent);
    int k, stall_left;
    if (sim_en) begin
      exp_q.push_back('{idx: 4'(sim_idx), ent: sim_ent});
      ref_mem[sim_idx] = sim_ent;
    end
    if (op <= 6) begin
      for (int i = 0; i < N; i++) begin
        if (i == mid_idx) begin
          for (int c = 0; c < mid_cnt; c++) begin
            exp_q.push_back('{idx: 4'(i), ent: mid_ent});
            ref_mem[i] = mid_ent;
          end
        end
        if (ref_hit(ref_mem[i], op, asid, va)) begin
          exp_q.push_back('{idx: 4'(i), ent: '0});
          ref_mem[i] = '0;
        end
      end
    end
    inv_valid = 1'b1; inv_op = 5'(op); inv_asid = asid; inv_vppn = va;
    ext_we = sim_en; ext_w_index = 4'(sim_idx); ext_w_entry = sim_ent;
    tick();
    inv_valid = 1'b0; ext_we = 1'b0;
    if (op > 6) begin
      chk("ine_pulse", 89'(inv_ine), 89'(1));
      chk("ine_busy", 89'(busy), 89'(0));
      tick();
      chk("ine_single", 89'(inv_ine), 89'(0));
      chk("ine_ready", 89'(inv_ready), 89'(1));
      return;
    end
    chk("busy_run", 89'(busy), 89'(1));
    k = 1;
    stall_left = mid_cnt;
    while (!inv_done && k < 200) begin
      if (stall_left > 0 && r_index == 4'(mid_idx)) begin
        ext_we = 1'b1; ext_w_index = 4'(mid_idx); ext_w_entry = mid_ent;
        stall_left--;
      end else begin
        ext_we = 1'b0;
      end
      tick();
      k++;
      if (ext_we) chk("stall_hold", 89'(r_index), 89'(mid_idx));
    end
    ext_we = 1'b0;
    chk("done_latency", 89'(k), 89'(N + 1 + mid_cnt));
    chk("busy_at_done", 89'(busy), 89'(0));
    tick();
    chk("done_single", 89'(inv_done), 89'(0));
    chk("ready_after", 89'(inv_ready), 89'(1));
  endtask

  function automatic logic [88:0] rand_ent();
    logic [18:0] v;
    v = {10'($urandom_range(0, 3)), 9'($urandom_range(0, 3))};
    return mk($urandom_range(0, 3) != 0, v, ($urandom_range(0, 1) != 0) ? 6'd12 : 6'd21,
              10'($urandom_range(0, 3)), $urandom_range(0, 1) != 0);
  endfunction

  initial begin
    logic [18:0] va;
    rstn = 1'b0; inv_valid = 1'b0; inv_op = '0; inv_asid = '0; inv_vppn = '0;
    ext_we = 1'b0; ext_w_index = '0; ext_w_entry = '0;
    fork monitor(); join_none
    tick(); tick();
    chk("rst_ready", 89'(inv_ready), 89'(1));
    chk("rst_busy", 89'(busy), 89'(0));
    chk("rst_done", 89'(inv_done), 89'(0));
    chk("rst_ine", 89'(inv_ine), 89'(0));
    chk("rst_rindex", 89'(r_index), 89'(0));
    rstn = 1'b1;
    tick();

    // op 0 clears every valid entry
    for (int i = 0; i < N; i++) ext_write(i, mk(1, 19'($urandom), 6'd12, 10'($urandom), 0));
    run_inv(0, 10'd0, 19'd0, 0, 0, '0, N, 0, '0);

    // op 4: only the non-global entry with the matching ASID
    for (int i = 0; i < N; i++) ext_write(i, mk(0, 19'd0, 6'd12, 10'd5, 0));
    ext_write(3, mk(1, 19'h00100, 6'd12, 10'd5, 1));
    ext_write(7, mk(1, 19'h00200, 6'd12, 10'd5, 0));
    run_inv(4, 10'd5, 19'd0, 0, 0, '0, N, 0, '0);
    chk("entry3_kept", 89'(tlb[3][88]), 89'(1));

    // op 5 with a large page compares VPPN[18:9] only; a 4 KiB page needs the full VPPN
    for (int i = 0; i < N; i++) ext_write(i, mk(0, 19'd0, 6'd12, 10'd0, 0));
    ext_write(9, mk(1, 19'h12A00, 6'd21, 10'd2, 0));
    run_inv(5, 10'd2, 19'h12BFF, 0, 0, '0, N, 0, '0);
    ext_write(9, mk(1, 19'h12A00, 6'd12, 10'd2, 0));
    run_inv(5, 10'd2, 19'h12BFF, 0, 0, '0, N, 0, '0);
    chk("entry9_kept", 89'(tlb[9][88]), 89'(1));

    // illegal op
    run_inv(7, 10'd0, 19'd0, 0, 0, '0, N, 0, '0);

    // external write stalls the walk at index 4 for two cycles
    for (int i = 0; i < N; i++) ext_write(i, mk(1, 19'($urandom), 6'd12, 10'd1, 0));
    run_inv(0, 10'd0, 19'd0, 0, 0, '0, 4, 2, mk(0, 19'h1, 6'd12, 10'd1, 0));

    // simultaneous ext write and request: walk sees the new entry
    for (int i = 0; i < N; i++) ext_write(i, mk(0, 19'd0, 6'd12, 10'd0, 0));
    run_inv(3, 10'd0, 19'd0, 1, 11, mk(1, 19'h5, 6'd12, 10'd0, 0), N, 0, '0);

    // reset mid-walk at index 6
    for (int i = 0; i < N; i++) ext_write(i, mk(1, 19'($urandom), 6'd12, 10'd0, 0));
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{idx: 4'(i), ent: '0});
      ref_mem[i] = '0;
    end
    inv_valid = 1'b1; inv_op = 5'd0;
    tick();
    inv_valid = 1'b0;
    for (int k = 0; k < 40 && r_index != 4'd6; k++) tick();
    chk("reached_idx6", 89'(r_index), 89'(6));
    rstn = 1'b0;
    #1;
    chk("rst_mid_we", 89'(we), 89'(0));
    chk("rst_mid_ready", 89'(inv_ready), 89'(1));
    chk("rst_mid_busy", 89'(busy), 89'(0));
    chk("rst_mid_rindex", 89'(r_index), 89'(0));
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_ready", 89'(inv_ready), 89'(1));
    for (int i = 0; i < N; i++) chk("post_rst_mem", tlb[i], ref_mem[i]);

    // randomized requests against the reference model
    for (int it = 0; it < 14; it++) begin
      for (int i = 0; i < N; i++) ext_write(i, rand_ent());
      va = ref_mem[$urandom_range(0, N - 1)][87:69];
      if ($urandom_range(0, 1) != 0) va[8:0] = 9'($urandom_range(0, 3));
      run_inv($urandom_range(0, 8), 10'($urandom_range(0, 3)), va,
              $urandom_range(0, 2) == 0, $urandom_range(0, N - 1), rand_ent(),
              $urandom_range(0, N - 1), $urandom_range(0, 2), rand_ent());
      for (int i = 0; i < N; i++) chk("rand_mem", tlb[i], ref_mem[i]);
    end

    tick();
    chk("queue_drained", 89'(exp_q.size()), 89'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
